// File: rtl/compare_run_counter_if.sv
// compare_run_counter_if: valid/ready word stream into the run counter
interface compare_run_counter_if #(
   parameter int WIDTH = 6
);
   logic             x_valid;
   logic [WIDTH-1:0] x_in;
   logic             x_ready;
   modport master (output x_valid, x_in, input x_ready);
   modport slave (input x_valid, x_in, output x_ready);
endinterface

// File: rtl/compare_run_counter.sv
// compare_run_counter: keyed equality/inequality compare over a fixed-length word run with saturating hit count
module compare_run_counter #(
   parameter int WIDTH   = 6,
   parameter int CNT_W   = 4,
   parameter int RUN_LEN = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_load,
   input  logic [WIDTH-1:0]       key_in,
   input  logic                   start,
   input  logic                   select,
   compare_run_counter_if.slave   x,
   output logic                   result,
   output logic                   result_valid,
   output logic [CNT_W-1:0]       hit_count,
   output logic                   done,
   output logic                   busy
);
   localparam int WC_W = $clog2(RUN_LEN + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] key;
   logic             mode;
   logic [WC_W-1:0]  word_cnt;
   logic             accept, match, last, setup;
   assign accept = x.x_valid & x.x_ready;
   assign match  = mode ? (x.x_in != key) : (x.x_in == key);
   assign last   = word_cnt == WC_W'(RUN_LEN - 1);
   assign setup  = state != RUN;
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   // next state: start launches a run from IDLE or DONE, final accept ends it
   always_comb begin
      state_nx = state;
      if (setup && start) state_nx = RUN;
      else if (state == RUN && accept && last) state_nx = DONE;
   end
   // Moore outputs decoded from state
   always_comb begin
      x.x_ready = state == RUN;
      busy      = state == RUN;
      done      = state == DONE;
   end
   // key/mode capture outside a run, per-word result and saturating hit count
   always_ff @(posedge clk) begin
      if (reset) begin
         key          <= '0;
         mode         <= 1'b0;
         word_cnt     <= '0;
         result       <= 1'b0;
         result_valid <= 1'b0;
         hit_count    <= '0;
      end else begin
         result_valid <= accept;
         if (setup && key_load) key <= key_in;
         if (setup && start) begin
            mode      <= select;
            word_cnt  <= '0;
            hit_count <= '0;
         end
         if (accept) begin
            result   <= match;
            word_cnt <= word_cnt + 1'b1;
            if (match && hit_count != '1) hit_count <= hit_count + 1'b1;
         end
      end
   end
endmodule
